// File: rtl/argmax_sequencer.sv
// Streaming argmax over IC signed Q8.8 class scores, one beat per cycle, with a registered valid/ready result.
// Optional macro ARGMAX_SEQUENCER_SCORE_OUT_EN adds out_score, the winning maximum value.
module argmax_sequencer #(
   parameter int IC         = 10,
   parameter int OUTPUT_BIT = $clog2(IC + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [15:0]           in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUTPUT_BIT-1:0] out_class,
   output logic                  busy,
`ifdef ARGMAX_SEQUENCER_SCORE_OUT_EN
   output logic [15:0]           out_score,
`endif
   output logic                  dbg_state
);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam logic [OUTPUT_BIT-1:0] LAST_CNT = OUTPUT_BIT'(IC - 1);

   state_t                state;
   state_t                state_next;
   logic [OUTPUT_BIT-1:0] cnt;
   logic [OUTPUT_BIT-1:0] idx;
   logic [15:0]           max_q;
   logic                  accept;
   logic                  last_beat;
   logic                  beat_wins;
   logic [OUTPUT_BIT-1:0] idx_next;
   logic [15:0]           max_next;

   // Handshake: a beat transfers on a rising edge with in_valid && in_ready;
   // a result transfers on a rising edge with out_valid && out_ready.
   assign accept    = in_valid && in_ready;
   assign last_beat = (cnt == LAST_CNT);

   // First beat of a frame always seeds the maximum; strict > keeps the lowest index on ties.
   assign beat_wins = (cnt == '0) || ($signed(in_data) > $signed(max_q));
   assign max_next  = beat_wins ? in_data : max_q;
   assign idx_next  = beat_wins ? cnt : idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACCUM;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         ACCUM: begin
            in_ready = !rst;
            if (in_valid && !rst && last_beat) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = ACCUM;
            end
         end
         default: state_next = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         idx       <= '0;
         max_q     <= '0;
         out_class <= '0;
      end else if (accept) begin
         max_q <= max_next;
         idx   <= idx_next;
         if (last_beat) begin
            cnt       <= '0;
            out_class <= idx_next;
         end else begin
            cnt <= cnt + OUTPUT_BIT'(1);
         end
      end
   end

`ifdef ARGMAX_SEQUENCER_SCORE_OUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         out_score <= '0;
      end else if (accept && last_beat) begin
         out_score <= max_next;
      end
   end
`endif

   assign busy      = (cnt != '0) || (state == HOLD);
   assign dbg_state = (state == HOLD);

endmodule

// File: doc/argmax_sequencer.md
Name: argmax_sequencer

Overview:
- Sequential front end for final classification: accepts the IC FC-layer class scores (signed Q8.8) one per cycle over a valid/ready stream.
- Tracks a running maximum and its index, then presents the winning class index on a registered valid/ready output.
- Sits between the serialised FC-layer output and the top-level result register.
- Replaces the wide IC×16-bit parallel compare with one 16-bit comparator per cycle.

Parameters:
- IC, 10, number of class scores per frame (≥1).
- OUTPUT_BIT, $clog2(IC+1), width of class index and of internal beat counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  score beat valid.
- in_ready  output  1  block can accept a score beat.
- in_data  input  16  signed Q8.8 class score; beat k of a frame is class k.
- out_valid  output  1  out_class holds a completed frame result.
- out_ready  input  1  downstream accepts result.
- out_class  output  OUTPUT_BIT  index of largest score in the frame.
- busy  output  1  high when the current frame has ≥1 beat accepted, or when a result is pending.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). While rst=1 at a clock edge, the block clears all state:
  - state=ACCUM, cnt=0, max=0, idx=0.
  - out_valid=0, out_class=0, busy=0.
  - in_ready is forced to 0 while rst is high.
- Reset mid-frame or while a result is pending discards the partial frame or result. No output is produced for it.
- Accept and release rules:
  - A beat is accepted when in_valid && in_ready at a rising edge.
  - A result is released when out_valid && out_ready.
- States:
  - ACCUM: in_ready=1, out_valid=0.
    - Accepted beat with cnt==0: max<=in_data, idx<=0.
    - Accepted beat with cnt>0: if in_data > max (signed, strict), then max<=in_data and idx<=cnt. Otherwise hold max and idx.
    - Each accepted beat increments cnt.
    - Beat accepted with cnt==IC-1: the update for that beat is applied. The final index, including that beat, is registered into out_class. State goes to HOLD and out_valid=1 from the next cycle. cnt resets to 0.
  - HOLD: in_ready=0, out_valid=1.
    - out_class is stable until release.
    - On release: next state ACCUM, out_valid=0.
    - There is no same-cycle bypass. The first beat of the next frame is accepted at the earliest on the cycle after release.
- Latency: out_valid rises 1 cycle after the edge that accepts the last beat. Maximum throughput is one frame per IC+1 cycles.
- Ties resolve to the lowest index (strict >). All equal scores give class 0.
- Comparison is full 16-bit signed. 0x8000 (−128.0) is the minimum and 0x7FFF is the maximum. No saturation or rounding is applied.
- IC=1: the first accepted beat completes the frame, and out_class=0.
- in_valid bubbles in ACCUM stall the frame without penalty. cnt, max and idx hold.
- in_data is ignored when in_valid=0, and in HOLD.
- out_ready is ignored when out_valid=0.

Optional Feature:
- Macro: ARGMAX_SEQUENCER_SCORE_OUT_EN.
- Defined:
  - Adds output port out_score (output, 16, signed Q8.8): the winning max value.
  - Registered together with out_class and held stable while out_valid=1.
  - Reset value 0.
- Undefined:
  - Port absent.
  - max remains internal only.
  - Behaviour otherwise identical.

Test Plan:
1. IC=10, back-to-back beats 0x0100,0xFF00,0x0300,0x0200,0x0000,0x0080,0xFE00,0x02FF,0x0001,0x0010 with out_ready=1 -> out_valid=1 for exactly 1 cycle, 1 cycle after the 10th beat; out_class=2; with the macro, out_score=0x0300.
2. Tie: beats 0x0500 at classes 3 and 7, all others 0x0000 -> out_class=3. All ten beats 0xFFFF -> out_class=0.
3. Negative/extreme: class 0=0x8000, classes 1–8=0x8000, class 9=0x8001 -> out_class=9. Class 4=0x7FFF, others 0x8000 -> out_class=4.
4. Backpressure: complete a frame with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and out_class stable throughout; raise out_ready -> release; in_ready=1 next cycle; second frame is accepted correctly.
5. Bubbles: in_valid toggled 1,0,0,1,… across a frame whose max is at class 6 -> out_class=6; out_valid only after the 10th accepted beat.
6. Reset: assert rst for 1 cycle after 4 beats -> out_valid, out_class and busy are 0; a new full frame then gives the correct index uncorrupted by the discarded beats. Assert rst while in HOLD -> out_valid=0 next cycle and in_ready=1 after rst falls.
